seqdect_ctrl: RTL and testbench

Run controller for serial pattern detection on the PORT X / PORT Z bit stream.
- Holds a programmable pattern of 1..MAX_LEN bits, length, overlap mode and a target match count.
- Arms on start, qualifies incoming bits, and pulses prtz on each match.
- Counts matches and finishes on target reached, window timeout or abort.
- Sits between the configuration/host logic and the serial input, in place of a fixed-pattern detector.

---
 rtl/seqdect_ctrl.sv | 146 ++++++++++++++
 tb/tb_seqdect_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seqdect_ctrl.sv
// seqdect_ctrl: run controller for a programmable serial pattern detector.
// Holds the pattern configuration, shifts qualified prtx bits into a history
// register, pulses prtz on every match and ends the run on target count,
// window timeout or abort. All outputs are registered.
module seqdect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int WINDOW  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               prtx,
  input  logic               prtx_vld,
  output logic               prtz,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               cfg_err
);

  localparam int BS_W = $clog2(MAX_LEN + 1);
  localparam int BC_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [3:0]         len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [MAX_LEN-1:0] hist;
  logic [BS_W-1:0]    bits_seen;
  logic [BC_W-1:0]    bit_cnt;

  logic               cfg_ok;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_nx;
  logic [BS_W-1:0]    seen_nx;
  logic [BC_W-1:0]    bit_cnt_nx;
  logic               hit;
  logic [CNT_W-1:0]   cnt_nx;
  logic               tgt_hit;
  logic               win_hit;

  // Next-bit view of the run: history, fill level, match and exit conditions
  // as they would be after accepting the current prtx.
  always_comb begin
    cfg_ok = (cfg_len != 4'd0) && (32'(cfg_len) <= MAX_LEN);
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < 32'(len_q));
    hist_nx    = {hist[MAX_LEN-2:0], prtx};
    seen_nx    = (32'(bits_seen) >= MAX_LEN) ? bits_seen : bits_seen + 1'b1;
    bit_cnt_nx = bit_cnt + 1'b1;
    hit        = (32'(seen_nx) >= 32'(len_q)) && ((hist_nx & mask) == (pat_q & mask));
    cnt_nx     = (hit && (match_cnt != '1)) ? match_cnt + 1'b1 : match_cnt;
    tgt_hit    = (tgt_q != '0) && (cnt_nx == tgt_q);
    win_hit    = (32'(bit_cnt_nx) == WINDOW);
  end

  // Control FSM with configuration registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= 4'd1;
      ovl_q     <= 1'b0;
      tgt_q     <= '0;
      hist      <= '0;
      bits_seen <= '0;
      bit_cnt   <= '0;
      prtz      <= 1'b0;
      match_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      prtz    <= 1'b0;
      cfg_err <= 1'b0;
      // Configuration is only writable outside a run; start on the same
      // edge therefore sees the new values from its first bit onwards.
      if (cfg_wr) begin
        if ((state != RUN) && cfg_ok) begin
          pat_q <= cfg_pattern;
          len_q <= cfg_len;
          ovl_q <= cfg_overlap;
          tgt_q <= cfg_target;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            match_cnt <= '0;
            hist      <= '0;
            bits_seen <= '0;
            bit_cnt   <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (prtx_vld) begin
            hist      <= hist_nx;
            bit_cnt   <= bit_cnt_nx;
            match_cnt <= cnt_nx;
            prtz      <= hit;
            // Without overlap the matched bits must not count toward the next match.
            bits_seen <= (hit && !ovl_q) ? '0 : seen_nx;
            if (tgt_hit) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              timeout <= 1'b0;
            end else if (win_hit) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              timeout <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seqdect_ctrl.sv
// tb_seqdect_ctrl: table-driven directed test of seqdect_ctrl (WINDOW=16),
// plus a hand-written bounded run to the window timeout.
module tb_seqdect_ctrl;

  logic       clk = 1'b0;
  logic       rst, cfg_wr, cfg_overlap, start, abort, prtx, prtx_vld;
  logic [7:0] cfg_pattern, cfg_target;
  logic [3:0] cfg_len;
  logic       prtz, busy, done, timeout, cfg_err;
  logic [7:0] match_cnt;

  seqdect_ctrl #(.MAX_LEN(8), .CNT_W(8), .WINDOW(16)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort), .prtx(prtx), .prtx_vld(prtx_vld),
    .prtz(prtz), .match_cnt(match_cnt), .busy(busy), .done(done),
    .timeout(timeout), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // One clock cycle: inputs applied before the edge, outputs expected after it.
  typedef struct {
    logic       r, cw;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic [7:0] tgt;
    logic       st, ab, x, xv;
    logic       ez;
    logic [7:0] ec;
    logic       eb, ed, et, ee;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic push(input logic r, input logic cw, input logic [7:0] pat,
                      input logic [3:0] len, input logic ov, input logic [7:0] tgt,
                      input logic st, input logic ab, input logic x, input logic xv,
                      input logic ez, input logic [7:0] ec, input logic eb,
                      input logic ed, input logic et, input logic ee);
    vec_t v;
    v.r = r; v.cw = cw; v.pat = pat; v.len = len; v.ov = ov; v.tgt = tgt;
    v.st = st; v.ab = ab; v.x = x; v.xv = xv;
    v.ez = ez; v.ec = ec; v.eb = eb; v.ed = ed; v.et = et; v.ee = ee;
    vecs.push_back(v);
  endtask

  task automatic rstv();
    push(1, 0, 8'h00, 4'd0, 0, 8'h00, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0);
  endtask

  task automatic ctl(input logic cw, input logic [7:0] pat, input logic [3:0] len,
                     input logic ov, input logic [7:0] tgt, input logic st,
                     input logic ab, input logic [7:0] ec, input logic eb,
                     input logic ed, input logic et, input logic ee);
    push(0, cw, pat, len, ov, tgt, st, ab, 0, 0, 0, ec, eb, ed, et, ee);
  endtask

  task automatic bitv(input logic x, input logic ez, input logic [7:0] ec,
                      input logic eb, input logic ed, input logic et);
    push(0, 0, 8'h00, 4'd0, 0, 8'h00, 0, 0, x, 1, ez, ec, eb, ed, et, 0);
  endtask

  task automatic gap(input logic [7:0] ec, input logic eb, input logic ed, input logic et);
    push(0, 0, 8'h00, 4'd0, 0, 8'h00, 0, 0, 1, 0, 0, ec, eb, ed, et, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.r; cfg_wr = v.cw; cfg_pattern = v.pat; cfg_len = v.len;
    cfg_overlap = v.ov; cfg_target = v.tgt; start = v.st; abort = v.ab;
    prtx = v.x; prtx_vld = v.xv;
  endtask

  initial begin
    vec_t idle_v;
    int   nbits;
    int   ncyc;
    logic saw_prtz;

    // Reset
    rstv();
    // 1: 0101 len4 overlap, no target
    ctl(1, 8'h05, 4'd4, 1, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0);
    ctl(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0, 0);
    bitv(0, 0, 8'd0, 1, 0, 0);
    bitv(1, 0, 8'd0, 1, 0, 0);
    bitv(0, 0, 8'd0, 1, 0, 0);
    bitv(1, 1, 8'd1, 1, 0, 0);
    bitv(0, 0, 8'd1, 1, 0, 0);
    bitv(1, 1, 8'd2, 1, 0, 0);
    bitv(0, 0, 8'd2, 1, 0, 0);
    ctl(0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 8'd2, 0, 0, 0, 0);
    // 2: same pattern, no overlap, gap in the stream
    ctl(1, 8'h05, 4'd4, 0, 8'd0, 0, 0, 8'd2, 0, 0, 0, 0);
    ctl(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0, 0);
    bitv(0, 0, 8'd0, 1, 0, 0);
    bitv(1, 0, 8'd0, 1, 0, 0);
    bitv(0, 0, 8'd0, 1, 0, 0);
    bitv(1, 1, 8'd1, 1, 0, 0);
    bitv(0, 0, 8'd1, 1, 0, 0);
    gap(8'd1, 1, 0, 0);
    bitv(1, 0, 8'd1, 1, 0, 0);
    bitv(0, 0, 8'd1, 1, 0, 0);
    bitv(1, 1, 8'd2, 1, 0, 0);
    ctl(0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 8'd2, 0, 0, 0, 0);
    // 3: target=2, cfg_wr and start in the same cycle
    ctl(1, 8'h05, 4'd4, 1, 8'd2, 1, 0, 8'd0, 1, 0, 0, 0);
    bitv(0, 0, 8'd0, 1, 0, 0);
    bitv(1, 0, 8'd0, 1, 0, 0);
    bitv(0, 0, 8'd0, 1, 0, 0);
    bitv(1, 1, 8'd1, 1, 0, 0);
    bitv(0, 0, 8'd1, 1, 0, 0);
    bitv(1, 1, 8'd2, 0, 1, 0);
    bitv(1, 0, 8'd2, 0, 1, 0);
    // 4: cfg_wr in DONE keeps results; window timeout with gaps
    ctl(1, 8'h0F, 4'd4, 0, 8'd0, 0, 0, 8'd2, 0, 1, 0, 0);
    ctl(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      if (i % 4 == 0) gap(8'd0, 1, 0, 0);
      if (i < 16) bitv(0, 0, 8'd0, 1, 0, 0);
      else        bitv(0, 0, 8'd0, 0, 1, 1);
    end
    // 5: cfg_wr in RUN rejected, abort beats start, reset mid-run
    ctl(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0, 0);
    ctl(1, 8'h05, 4'd4, 1, 8'd0, 0, 0, 8'd0, 1, 0, 0, 1);
    bitv(1, 0, 8'd0, 1, 0, 0);
    bitv(1, 0, 8'd0, 1, 0, 0);
    bitv(1, 0, 8'd0, 1, 0, 0);
    bitv(1, 1, 8'd1, 1, 0, 0);
    ctl(0, 8'h00, 4'd0, 0, 8'd0, 1, 1, 8'd1, 0, 0, 0, 0);
    ctl(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0, 0);
    bitv(1, 0, 8'd0, 1, 0, 0);
    bitv(1, 0, 8'd0, 1, 0, 0);
    bitv(1, 0, 8'd0, 1, 0, 0);
    rstv();
    // 6: bad cfg_len rejected; run uses reset config (pattern 0, len 1, no overlap)
    ctl(1, 8'hFF, 4'd0, 1, 8'd3, 0, 0, 8'd0, 0, 0, 0, 1);
    ctl(1, 8'hFF, 4'd9, 1, 8'd3, 0, 0, 8'd0, 0, 0, 0, 1);
    ctl(0, 8'h00, 4'd0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 0);
    ctl(0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0, 0);
    bitv(0, 1, 8'd1, 1, 0, 0);
    bitv(1, 0, 8'd1, 1, 0, 0);
    bitv(0, 1, 8'd2, 1, 0, 0);
    ctl(0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 8'd2, 0, 0, 0, 0);

    idle_v = vecs[0];
    idle_v.r = 1'b0;
    drive(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d {prtz,cnt,busy,done,timeout,cfg_err}", i),
          {19'd0, prtz, match_cnt, busy, done, timeout, cfg_err},
          {19'd0, vecs[i].ez, vecs[i].ec, vecs[i].eb, vecs[i].ed, vecs[i].et, vecs[i].ee});
    end

    // Hand-written: pattern 1 len1, feed zeros until the window closes.
    @(negedge clk);
    drive(idle_v);
    cfg_wr = 1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1; cfg_target = 8'd0;
    start = 1;
    @(negedge clk);
    drive(idle_v);
    nbits = 0; ncyc = 0; saw_prtz = 0;
    while (!done && ncyc < 60) begin
      ncyc++;
      prtx = 0;
      prtx_vld = (ncyc % 3 != 0);
      @(posedge clk);
      #1;
      if (prtx_vld) nbits++;
      if (prtz) saw_prtz = 1;
      @(negedge clk);
    end
    drive(idle_v);
    chk("window run finished in budget", {31'd0, done}, 32'd1);
    chk("window valid bit count", nbits, 32'd16);
    chk("window timeout flag", {31'd0, timeout}, 32'd1);
    chk("window no match", {23'd0, saw_prtz, match_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
